iddrx2_deser: RTL and testbench
===============================

// Module: iddrx2_deser
// PURPOSE
//  Read-side counterpart of the 4:1 DDR output serializer. Takes one rise/fall bit pair per
//  ECLK cycle from the DQ input capture flops and rebuilds 4-bit words in serializer order
//  (D0=first rise, D1=first fall, D2=second rise, D3=second fall). Emits one word per two
//  enabled pairs. A bitslip (ALIGN) input moves the word boundary so read leveling can lock.
// PARAMETERS
//  WIDTH          1  number of independent lanes (DQ bits), all sharing one offset/phase
//  ALIGN_HOLDOFF  4  cycles BUSY stays high after an accepted ALIGN (range 1..15)
// PORTS
//  ECLK   in   1      edge clock; all logic on rising edge
//  RST    in   1      synchronous, active-high reset
//  EN     in   1      DR/DF carry a valid bit pair this cycle
//  DR     in   WIDTH  bit sampled on rising DQS edge (earlier in time)
//  DF     in   WIDTH  bit sampled on falling DQS edge (later in time)
//  ALIGN  in   1      bitslip request; one-cycle pulse
//  Q0..Q3 out  WIDTH  deserialized word, Q0 oldest bit
//  VALID  out  1      Q0..Q3 hold a new word this cycle (one-cycle pulse)
//  BUSY   out  1      ALIGN holdoff active; ALIGN ignored, VALID forced 0
// BEHAVIOUR
//  - One clock ECLK; reset synchronous, active-high, on RST.
//  - Reset: history h=0, offset=0, phase tgl=0, holdoff cnt=0; Q0..Q3=0, VALID=0, BUSY=0.
//  - Per lane history h[0..6], h[0] newest. On EN=1: h <= {h[4:0], DR, DF}, i.e. h[1]<=DR,
//    h[0]<=DF, older bits move up by 2; tgl <= ~tgl. EN=0: h and tgl hold.
//  - Emission: on a cycle with EN=1 and tgl=1 (second pair of a word), next edge registers
//    Q3=h'[k], Q2=h'[k+1], Q1=h'[k+2], Q0=h'[k+3] with h' = history including this pair and
//    k = offset; VALID=1 one cycle after the second pair is presented (latency 1).
//  - VALID=0 on all other cycles; Q0..Q3 hold last word between emissions.
//  - ALIGN accepted when ALIGN=1 and BUSY=0 (EN irrelevant): offset <= (offset+1) mod 4
//    (3 wraps to 0, tgl untouched); cnt <= ALIGN_HOLDOFF; BUSY=1 from next cycle.
//  - While cnt!=0: cnt decrements each cycle; BUSY=1; ALIGN ignored; h/tgl still advance;
//    Q0..Q3 and VALID not updated (VALID=0). BUSY drops the cycle after cnt reaches 0.
//  - Emission coinciding with an accepted ALIGN is suppressed (VALID=0, Q held).
//  - Each accepted ALIGN delays the word boundary by one bit; 4 ALIGNs = original framing.
//  - RST mid-holdoff or mid-word: everything returns to reset values next cycle.
//  - Lanes are independent bit-for-bit; no cross-lane arithmetic.
// TESTING
//  1. RST=1 2 cycles with random DR/DF/EN/ALIGN -> Q0..Q3=0, VALID=0, BUSY=0.
//  2. WIDTH=1, EN=1 after reset, pairs (1,0),(1,1),(0,0),(0,1) -> VALID cycle after pair 2
//     with Q0..Q3=1,0,1,1; next VALID two cycles later with 0,0,0,1; VALID never adjacent.
//  3. Repeating pairs (1,0),(0,0), first pair on first EN cycle: Q0..Q3=1,0,0,0; pulse ALIGN,
//     wait BUSY low -> 0,1,0,0; again -> 0,0,1,0; again -> 0,0,0,1; 4th -> 1,0,0,0.
//  4. ALIGN pulses on each of the 4 cycles after an accepted ALIGN -> ignored, offset +1 only,
//     BUSY high exactly ALIGN_HOLDOFF cycles, no VALID during BUSY.
//  5. EN low 3 cycles between pair 1 and 2 of a word -> VALID delayed 3 cycles, word identical
//     to gap-free run; no VALID while EN=0.
//  6. RST asserted 2 cycles into holdoff with offset=1 -> BUSY=0, offset 0 framing restored
//     (test 3 stream yields 1,0,0,0 again).

Source files
------------

// File: rtl/iddrx2_deser.sv
// iddrx2_deser: 4:1 DDR input deserializer with bitslip alignment.
// Rebuilds 4-bit words from rise/fall bit pairs in serializer order
// (Q0 = first rise, Q1 = first fall, Q2 = second rise, Q3 = second fall).
// ALIGN shifts the word boundary one bit later, then blocks itself and
// word output for ALIGN_HOLDOFF cycles while the new framing settles.
module iddrx2_deser #(
  parameter int WIDTH         = 1,
  parameter int ALIGN_HOLDOFF = 4   // legal range 1..15
) (
  input  logic             ECLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DR,
  input  logic [WIDTH-1:0] DF,
  input  logic             ALIGN,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic             VALID,
  output logic             BUSY
);

  localparam int HIST_W = 7;   // 4 word bits + up to 3 bits of bitslip reach
  localparam int CNT_W  = 4;

  // Per-lane bit history, bit 0 newest.
  logic [WIDTH-1:0][HIST_W-1:0] hist;
  logic [WIDTH-1:0][HIST_W-1:0] hist_next;
  logic [1:0]                   offset;    // word boundary delay in bits
  logic                         tgl;       // 1 = next enabled pair completes a word
  logic [CNT_W-1:0]             cnt;       // remaining holdoff cycles

  logic                         accept;
  logic                         emit;
  logic [WIDTH-1:0]             w0, w1, w2, w3;
  logic [2:0]                   k;

  assign BUSY = (cnt != '0);
  assign k    = {1'b0, offset};

  // Decode alignment/emission and select the framed word from the updated history.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    hist_next = hist;
    w0        = '0;
    w1        = '0;
    w2        = '0;
    w3        = '0;
    accept    = ALIGN && !BUSY;
    emit      = EN && tgl && !BUSY && !accept;
    for (int i = 0; i < WIDTH; i++) begin
      if (EN) begin
        hist_next[i] = {hist[i][4:0], DR[i], DF[i]};
      end
      w3[i] = hist_next[i][k];
      w2[i] = hist_next[i][k + 3'd1];
      w1[i] = hist_next[i][k + 3'd2];
      w0[i] = hist_next[i][k + 3'd3];
    end
  end

  // History, pair phase, offset and holdoff counter.
  always_ff @(posedge ECLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      // NOTE: the history is cleared on reset (not left to flush) because a
      // bitslipped first word reads bits older than anything received so far.
      hist   <= '0;
      tgl    <= 1'b0;
      offset <= 2'd0;
      cnt    <= '0;
    end else begin
      hist <= hist_next;
      if (EN) begin
        tgl <= ~tgl;
      end
      if (accept) begin
        offset <= offset + 2'd1;
        cnt    <= CNT_W'(ALIGN_HOLDOFF);
      end else if (BUSY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Output word register; Q holds between emissions.
  always_ff @(posedge ECLK) begin
    if (RST) begin
      Q0    <= '0;
      Q1    <= '0;
      Q2    <= '0;
      Q3    <= '0;
      VALID <= 1'b0;
    end else begin
      VALID <= emit;
      if (emit) begin
        Q0 <= w0;
        Q1 <= w1;
        Q2 <= w2;
        Q3 <= w3;
      end
    end
  end

endmodule

// File: tb/tb_iddrx2_deser.sv
// Testbench for iddrx2_deser: directed scenarios plus a random run, all
// compared cycle by cycle against a bit-stream reference model.
module tb_iddrx2_deser;

  localparam int W = 2;
  localparam int H = 4;

  logic         ECLK = 1'b0;
  logic         RST = 1'b1, EN = 1'b0, ALIGN = 1'b0;
  logic [W-1:0] DR = '0, DF = '0;
  logic [W-1:0] Q0, Q1, Q2, Q3;
  logic         VALID, BUSY;

  int errors = 0;
  int checks = 0;
  int p = 0;   // pair index for the repeating (1,0),(0,0) stream on lane 0

  iddrx2_deser #(.WIDTH(W), .ALIGN_HOLDOFF(H)) dut (
    .ECLK(ECLK), .RST(RST), .EN(EN), .DR(DR), .DF(DF), .ALIGN(ALIGN),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .VALID(VALID), .BUSY(BUSY)
  );

  always #5 ECLK = ~ECLK;

  // Reference model: the received bit stream in arrival order, number of
  // pairs since reset, number of accepted bitslips and the busy window.
  logic [W-1:0] m_stream[$];
  int           m_pairs = 0, m_accepts = 0, m_edge = 0;
  int           m_busy_from = -10, m_busy_to = -10;
  logic         m_valid = 1'b0, m_busy = 1'b0;
  logic [W-1:0] m_q[4];

  // Bit received 'ago' bits before the newest one (zeros before reset).
  function automatic logic [W-1:0] bits_ago(input int ago);
    if (ago < m_stream.size()) return m_stream[m_stream.size() - 1 - ago];
    return '0;
  endfunction

  task automatic model_edge(input logic rst, en, align, input logic [W-1:0] dr, df);
    logic busy_before, accept, emit;
    int   k;
    m_edge++;
    if (rst) begin
      m_stream.delete();
      m_pairs = 0; m_accepts = 0;
      m_busy_from = -10; m_busy_to = -10;
      m_valid = 1'b0; m_busy = 1'b0;
      foreach (m_q[i]) m_q[i] = '0;
    end else begin
      busy_before = m_busy;
      accept = align && !busy_before;
      emit = 1'b0;
      if (en) begin
        m_stream.push_back(dr);
        m_stream.push_back(df);
        while (m_stream.size() > 8) void'(m_stream.pop_front());
        m_pairs++;
        emit = (m_pairs % 2 == 0);
      end
      if (busy_before || accept) emit = 1'b0;
      m_valid = emit;
      if (emit) begin
        k = m_accepts % 4;
        m_q[3] = bits_ago(k);
        m_q[2] = bits_ago(k + 1);
        m_q[1] = bits_ago(k + 2);
        m_q[0] = bits_ago(k + 3);
      end
      if (accept) begin
        m_accepts++;
        m_busy_from = m_edge;
        m_busy_to = m_edge + H - 1;
      end
      m_busy = (m_edge >= m_busy_from) && (m_edge <= m_busy_to);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic step(input logic rst, en, align, input logic [W-1:0] dr, df);
    RST = rst; EN = en; ALIGN = align; DR = dr; DF = df;
    @(posedge ECLK);
    model_edge(rst, en, align, dr, df);
    #1;
  endtask

  // Lane 0 carries (1,0),(0,0) repeating; lane 1 carries (0,1),(0,0).
  task automatic stream_step(input logic align);
    logic b;
    b = (p % 2 == 0);
    step(1'b0, 1'b1, align, {1'b0, b}, {b, 1'b0});
    p++;
  endtask

  function automatic logic [3:0] lane0_word();
    return {Q0[0], Q1[0], Q2[0], Q3[0]};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      checks++;
      if ({Q0, Q1, Q2, Q3, VALID, BUSY} !== '0) begin
        errors++;
        $display("FAIL reset cyc=%0d got Q=%h_%h_%h_%h V=%b B=%b need all zero",
                 i, Q0, Q1, Q2, Q3, VALID, BUSY);
      end
    end
  endtask

  task automatic test_basic_words();
    logic [3:0] dr0 = 4'b1100, df0 = 4'b0101;   // pairs (1,0),(1,1),(0,0),(0,1)
    logic [3:0] need;
    logic [W-1:0] rdr, rdf;
    for (int i = 0; i < 4; i++) begin
      rdr = W'($urandom); rdf = W'($urandom);
      rdr[0] = dr0[3 - i]; rdf[0] = df0[3 - i];
      step(1'b0, 1'b1, 1'b0, rdr, rdf);
      checks++;
      if ({VALID, BUSY, Q0, Q1, Q2, Q3} !== {m_valid, m_busy, m_q[0], m_q[1], m_q[2], m_q[3]}) begin
        errors++;
        $display("FAIL basic_model cyc=%0d got V=%b B=%b Q=%h_%h_%h_%h need V=%b B=%b Q=%h_%h_%h_%h",
                 i, VALID, BUSY, Q0, Q1, Q2, Q3, m_valid, m_busy, m_q[0], m_q[1], m_q[2], m_q[3]);
      end
      need = (i == 1) ? 4'b1011 : 4'b0001;
      checks++;
      if (VALID !== 1'(i % 2) || (VALID === 1'b1 && lane0_word() !== need)) begin
        errors++;
        $display("FAIL basic_word cyc=%0d got V=%b Q0..Q3=%b need V=%b Q0..Q3=%b",
                 i, VALID, lane0_word(), 1'(i % 2), need);
      end
    end
  endtask

  task automatic test_bitslip_walk();
    logic [3:0] need;
    bit got;
    step(1'b1, 1'b0, 1'b0, '0, '0);
    p = 0;
    for (int i = 0; i < 4; i++) stream_step(1'b0);
    checks++;
    if (lane0_word() !== 4'b1000) begin
      errors++;
      $display("FAIL slip_initial got Q0..Q3=%b need 1000", lane0_word());
    end
    for (int a = 1; a <= 4; a++) begin
      stream_step(1'b1);
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        stream_step(1'b0);
        checks++;
        if ({VALID, BUSY, Q0, Q1, Q2, Q3} !== {m_valid, m_busy, m_q[0], m_q[1], m_q[2], m_q[3]}) begin
          errors++;
          $display("FAIL slip_model a=%0d got V=%b B=%b Q=%h_%h_%h_%h need V=%b B=%b Q=%h_%h_%h_%h",
                   a, VALID, BUSY, Q0, Q1, Q2, Q3, m_valid, m_busy, m_q[0], m_q[1], m_q[2], m_q[3]);
        end
        if (VALID === 1'b1) got = 1'b1;
      end
      need = 4'b1000 >> (a % 4);
      checks++;
      if (!got || lane0_word() !== need) begin
        errors++;
        $display("FAIL slip_word a=%0d got valid_seen=%b Q0..Q3=%b need %b", a, got, lane0_word(), need);
      end
    end
  endtask

  task automatic test_align_holdoff();
    int busy_cycles = 0, overlap = 0;
    bit got = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0, '0);
    p = 0;
    for (int i = 0; i < 4; i++) stream_step(1'b0);
    for (int i = 0; i < 5 + 12 && !got; i++) begin
      stream_step(i < 5);
      if (BUSY === 1'b1) busy_cycles++;
      if (VALID === 1'b1 && BUSY === 1'b1) overlap++;
      if (i >= 5 && VALID === 1'b1) got = 1'b1;
      checks++;
      if ({VALID, BUSY, Q0, Q1, Q2, Q3} !== {m_valid, m_busy, m_q[0], m_q[1], m_q[2], m_q[3]}) begin
        errors++;
        $display("FAIL holdoff_model i=%0d got V=%b B=%b Q=%h_%h_%h_%h need V=%b B=%b Q=%h_%h_%h_%h",
                 i, VALID, BUSY, Q0, Q1, Q2, Q3, m_valid, m_busy, m_q[0], m_q[1], m_q[2], m_q[3]);
      end
    end
    checks++;
    if (busy_cycles != H || overlap != 0) begin
      errors++;
      $display("FAIL holdoff_busy got busy_cycles=%0d overlap=%0d need %0d and 0", busy_cycles, overlap, H);
    end
    checks++;
    if (!got || lane0_word() !== 4'b0100) begin
      errors++;
      $display("FAIL holdoff_offset got valid_seen=%b Q0..Q3=%b need 0100", got, lane0_word());
    end
  endtask

  task automatic test_en_gap();
    logic [W-1:0] r;
    step(1'b1, 1'b0, 1'b0, '0, '0);
    r = W'($urandom);
    step(1'b0, 1'b1, 1'b0, {r[1], 1'b1}, {r[0], 1'b0});
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, W'($urandom), W'($urandom));
      checks++;
      if (VALID !== 1'b0) begin
        errors++;
        $display("FAIL gap_valid cyc=%0d got V=%b need 0", i, VALID);
      end
    end
    r = W'($urandom);
    step(1'b0, 1'b1, 1'b0, {r[1], 1'b1}, {r[0], 1'b1});
    checks++;
    if (VALID !== 1'b1 || lane0_word() !== 4'b1011) begin
      errors++;
      $display("FAIL gap_word got V=%b Q0..Q3=%b need V=1 Q0..Q3=1011", VALID, lane0_word());
    end
    checks++;
    if ({Q0, Q1, Q2, Q3} !== {m_q[0], m_q[1], m_q[2], m_q[3]}) begin
      errors++;
      $display("FAIL gap_model got Q=%h_%h_%h_%h need Q=%h_%h_%h_%h",
               Q0, Q1, Q2, Q3, m_q[0], m_q[1], m_q[2], m_q[3]);
    end
  endtask

  task automatic test_reset_in_holdoff();
    step(1'b1, 1'b0, 1'b0, '0, '0);
    p = 0;
    for (int i = 0; i < 4; i++) stream_step(1'b0);
    stream_step(1'b1);
    stream_step(1'b0);
    stream_step(1'b0);
    step(1'b1, 1'($urandom), 1'b1, W'($urandom), W'($urandom));
    checks++;
    if (BUSY !== 1'b0 || VALID !== 1'b0 || {Q0, Q1, Q2, Q3} !== '0) begin
      errors++;
      $display("FAIL holdoff_reset got B=%b V=%b Q=%h_%h_%h_%h need all zero", BUSY, VALID, Q0, Q1, Q2, Q3);
    end
    p = 0;
    for (int i = 0; i < 4; i++) stream_step(1'b0);
    checks++;
    if (VALID !== 1'b1 || BUSY !== 1'b0 || lane0_word() !== 4'b1000) begin
      errors++;
      $display("FAIL holdoff_reset_word got V=%b B=%b Q0..Q3=%b need V=1 B=0 Q0..Q3=1000",
               VALID, BUSY, lane0_word());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 5) == 0), W'($urandom), W'($urandom));
      checks++;
      if ({VALID, BUSY, Q0, Q1, Q2, Q3} !== {m_valid, m_busy, m_q[0], m_q[1], m_q[2], m_q[3]}) begin
        errors++;
        $display("FAIL random cyc=%0d got V=%b B=%b Q=%h_%h_%h_%h need V=%b B=%b Q=%h_%h_%h_%h",
                 i, VALID, BUSY, Q0, Q1, Q2, Q3, m_valid, m_busy, m_q[0], m_q[1], m_q[2], m_q[3]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_words();
    test_bitslip_walk();
    test_align_holdoff();
    test_en_gap();
    test_reset_in_holdoff();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
